// File: rtl/ad7705_sample_avg.sv
// Block averager for AD7705 sample codes: N = 2^LOG2_N samples per window, rounded mean,
// window min/max and a sticky rail flag. A new sample is marked by each rise of sample_rdy.
module ad7705_sample_avg #(
  parameter int unsigned LOG2_N = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] sample_in,
  input  logic        sample_rdy,
  input  logic        clear,
  output logic [15:0] avg_out,
  output logic        avg_vld,
  output logic [15:0] min_out,
  output logic [15:0] max_out,
  output logic [6:0]  fill_cnt,
  output logic        ovr
);

  localparam int unsigned AW = 16 + LOG2_N;
  localparam logic [6:0]  LAST = 7'((1 << LOG2_N) - 1);
  localparam logic [AW:0] HALF = (AW + 1)'((1 << LOG2_N) >> 1);

  typedef enum logic [0:0] {StEmpty, StAccum} state_e;

  state_e          state_q, state_d;
  logic            rdy_q;
  logic [AW-1:0]   acc_q, acc_d;
  logic [15:0]     run_min_q, run_min_d, run_max_q, run_max_d;
  logic [6:0]      fill_d;
  logic            ovr_d, vld_d;
  logic [15:0]     avg_d, min_d, max_d;
  logic            accept, last;
  logic [15:0]     new_min, new_max, avg_sat;
  logic [AW:0]     sum_full, avg_full;

  // Clear wins over a coinciding rise; the rise is still consumed through rdy_q.
  assign accept  = sample_rdy & ~rdy_q & ~clear;
  assign last    = (LOG2_N == 0) || ((state_q == StAccum) && (fill_cnt == LAST));
  assign new_min = (sample_in < run_min_q) ? sample_in : run_min_q;
  assign new_max = (sample_in > run_max_q) ? sample_in : run_max_q;

  assign sum_full = {1'b0, acc_q} + {{(LOG2_N + 1){1'b0}}, sample_in} + HALF;
  assign avg_full = sum_full >> LOG2_N;
  assign avg_sat  = (|avg_full[AW:16]) ? 16'hFFFF : avg_full[15:0];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    fill_d    = fill_cnt;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    ovr_d     = ovr;
    vld_d     = 1'b0;
    avg_d     = avg_out;
    min_d     = min_out;
    max_d     = max_out;
    if (clear) begin
      state_d   = StEmpty;
      acc_d     = '0;
      fill_d    = '0;
      run_min_d = 16'hFFFF;
      run_max_d = 16'h0000;
      ovr_d     = 1'b0;
    end else if (accept) begin
      if (sample_in == 16'h0000 || sample_in == 16'hFFFF) ovr_d = 1'b1;
      if (last) begin
        avg_d     = avg_sat;
        min_d     = new_min;
        max_d     = new_max;
        vld_d     = 1'b1;
        state_d   = StEmpty;
        acc_d     = '0;
        fill_d    = '0;
        run_min_d = 16'hFFFF;
        run_max_d = 16'h0000;
      end else begin
        state_d   = StAccum;
        acc_d     = acc_q + AW'(sample_in);
        fill_d    = fill_cnt + 7'd1;
        run_min_d = new_min;
        run_max_d = new_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StEmpty;
      rdy_q     <= 1'b1;
      acc_q     <= '0;
      fill_cnt  <= '0;
      run_min_q <= 16'hFFFF;
      run_max_q <= 16'h0000;
      ovr       <= 1'b0;
      avg_vld   <= 1'b0;
      avg_out   <= 16'h0000;
      min_out   <= 16'h0000;
      max_out   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      rdy_q     <= sample_rdy;
      acc_q     <= acc_d;
      fill_cnt  <= fill_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      ovr       <= ovr_d;
      avg_vld   <= vld_d;
      avg_out   <= avg_d;
      min_out   <= min_d;
      max_out   <= max_d;
    end
  end

endmodule

// File: tb/tb_ad7705_sample_avg.sv
// Directed bench for ad7705_sample_avg: an 8-sample instance and a single-sample instance.
module tb_ad7705_sample_avg;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] sample_in = 16'h0, sample_in1 = 16'h0;
  logic        sample_rdy = 1'b0, sample_rdy1 = 1'b0;
  logic        clear = 1'b0, clear1 = 1'b0;
  logic [15:0] avg_out, min_out, max_out, avg_out1, min_out1, max_out1;
  logic        avg_vld, ovr, avg_vld1, ovr1;
  logic [6:0]  fill_cnt, fill_cnt1;

  int total = 0;
  int bad = 0;
  int vld_cnt = 0;
  int vld1_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (avg_vld) vld_cnt++;
    if (avg_vld1) vld1_cnt++;
  end

  ad7705_sample_avg #(.LOG2_N(3)) dut (
    .clk(clk), .rstn(rstn), .sample_in(sample_in), .sample_rdy(sample_rdy), .clear(clear),
    .avg_out(avg_out), .avg_vld(avg_vld), .min_out(min_out), .max_out(max_out),
    .fill_cnt(fill_cnt), .ovr(ovr)
  );

  ad7705_sample_avg #(.LOG2_N(0)) dut1 (
    .clk(clk), .rstn(rstn), .sample_in(sample_in1), .sample_rdy(sample_rdy1), .clear(clear1),
    .avg_out(avg_out1), .avg_vld(avg_vld1), .min_out(min_out1), .max_out(max_out1),
    .fill_cnt(fill_cnt1), .ovr(ovr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One rise of sample_rdy with data, then a low cycle.
  task automatic send(input logic [15:0] v);
    sample_in  = v;
    sample_rdy = 1'b1;
    tick();
    sample_rdy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    total++; if (avg_out !== 16'h0) begin bad++; $display("FAIL reset_avg got %h want 0000", avg_out); end
    total++; if (min_out !== 16'h0) begin bad++; $display("FAIL reset_min got %h want 0000", min_out); end
    total++; if (max_out !== 16'h0) begin bad++; $display("FAIL reset_max got %h want 0000", max_out); end
    total++; if (avg_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got %b want 0", avg_vld); end
    total++; if (fill_cnt !== 7'd0) begin bad++; $display("FAIL reset_fill got %0d want 0", fill_cnt); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr got %b want 0", ovr); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int v0;
    v0 = vld_cnt;
    for (int i = 0; i < 4; i++) send(16'h1000 + 16'(i));
    total++; if (fill_cnt !== 7'd4) begin bad++; $display("FAIL basic_fill4 got %0d want 4", fill_cnt); end
    for (int i = 4; i < 7; i++) send(16'h1000 + 16'(i));
    total++; if (avg_out !== 16'h0) begin bad++; $display("FAIL basic_hold got %h want 0000", avg_out); end
    sample_in  = 16'h1007;
    sample_rdy = 1'b1;
    tick();
    total++; if (avg_vld !== 1'b1) begin bad++; $display("FAIL basic_vld got %b want 1", avg_vld); end
    total++; if (avg_out !== 16'h1004) begin bad++; $display("FAIL basic_avg got %h want 1004", avg_out); end
    total++; if (min_out !== 16'h1000) begin bad++; $display("FAIL basic_min got %h want 1000", min_out); end
    total++; if (max_out !== 16'h1007) begin bad++; $display("FAIL basic_max got %h want 1007", max_out); end
    total++; if (fill_cnt !== 7'd0) begin bad++; $display("FAIL basic_fill0 got %0d want 0", fill_cnt); end
    sample_rdy = 1'b0;
    tick();
    total++; if (avg_vld !== 1'b0) begin bad++; $display("FAIL basic_vld_one got %b want 0", avg_vld); end
    total++; if (vld_cnt - v0 !== 1) begin bad++; $display("FAIL basic_pulses got %0d want 1", vld_cnt - v0); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL basic_ovr got %b want 0", ovr); end
  endtask

  task automatic test_saturate();
    send(16'hFFFF);
    total++; if (ovr !== 1'b1) begin bad++; $display("FAIL sat_ovr_first got %b want 1", ovr); end
    for (int i = 1; i < 8; i++) send(16'hFFFF);
    total++; if (avg_out !== 16'hFFFF) begin bad++; $display("FAIL sat_avg got %h want FFFF", avg_out); end
    total++; if (min_out !== 16'hFFFF) begin bad++; $display("FAIL sat_min got %h want FFFF", min_out); end
    total++; if (ovr !== 1'b1) begin bad++; $display("FAIL sat_ovr_sticky got %b want 1", ovr); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL sat_ovr_clr got %b want 0", ovr); end
    total++; if (avg_out !== 16'hFFFF) begin bad++; $display("FAIL sat_avg_held got %h want FFFF", avg_out); end
    total++; if (max_out !== 16'hFFFF) begin bad++; $display("FAIL sat_max_held got %h want FFFF", max_out); end
  endtask

  task automatic test_held();
    int v0;
    v0 = vld_cnt;
    sample_in = 16'h0300;
    for (int k = 0; k < 8; k++) begin
      sample_rdy = 1'b1;
      repeat (20) tick();
      sample_rdy = 1'b0;
      tick();
    end
    total++; if (vld_cnt - v0 !== 1) begin bad++; $display("FAIL held_pulses got %0d want 1", vld_cnt - v0); end
    total++; if (avg_out !== 16'h0300) begin bad++; $display("FAIL held_avg got %h want 0300", avg_out); end
    total++; if (fill_cnt !== 7'd0) begin bad++; $display("FAIL held_fill got %0d want 0", fill_cnt); end
  endtask

  task automatic test_clear_mid();
    int v0;
    v0 = vld_cnt;
    for (int i = 0; i < 4; i++) send(16'h0500);
    total++; if (fill_cnt !== 7'd4) begin bad++; $display("FAIL clr_fill4 got %0d want 4", fill_cnt); end
    sample_in  = 16'h0500;
    sample_rdy = 1'b1;
    clear      = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (fill_cnt !== 7'd0) begin bad++; $display("FAIL clr_fill0 got %0d want 0", fill_cnt); end
    repeat (3) tick();
    total++; if (fill_cnt !== 7'd0) begin bad++; $display("FAIL clr_no_reaccept got %0d want 0", fill_cnt); end
    sample_rdy = 1'b0;
    tick();
    total++; if (vld_cnt - v0 !== 0) begin bad++; $display("FAIL clr_no_vld got %0d want 0", vld_cnt - v0); end
    total++; if (avg_out !== 16'h0300) begin bad++; $display("FAIL clr_avg_held got %h want 0300", avg_out); end
    for (int i = 0; i < 8; i++) send(16'h0100);
    total++; if (avg_out !== 16'h0100) begin bad++; $display("FAIL clr_after_avg got %h want 0100", avg_out); end
    total++; if (vld_cnt - v0 !== 1) begin bad++; $display("FAIL clr_after_pulses got %0d want 1", vld_cnt - v0); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send(16'h0700);
    rstn       = 1'b0;
    sample_rdy = 1'b1;
    sample_in  = 16'h0700;
    #2;
    total++; if (avg_out !== 16'h0) begin bad++; $display("FAIL rst_avg got %h want 0000", avg_out); end
    total++; if (fill_cnt !== 7'd0) begin bad++; $display("FAIL rst_fill got %0d want 0", fill_cnt); end
    tick();
    rstn = 1'b1;
    repeat (2) tick();
    total++; if (fill_cnt !== 7'd0) begin bad++; $display("FAIL rst_held_rdy got %0d want 0", fill_cnt); end
    sample_rdy = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) send(16'h2000);
    total++; if (avg_out !== 16'h2000) begin bad++; $display("FAIL rst_after_avg got %h want 2000", avg_out); end
    total++; if (min_out !== 16'h2000) begin bad++; $display("FAIL rst_after_min got %h want 2000", min_out); end
    total++; if (max_out !== 16'h2000) begin bad++; $display("FAIL rst_after_max got %h want 2000", max_out); end
  endtask

  task automatic test_single();
    logic [15:0] vals [2];
    int v0;
    vals[0] = 16'h0001;
    vals[1] = 16'h8000;
    for (int k = 0; k < 2; k++) begin
      v0 = vld1_cnt;
      sample_in1  = vals[k];
      sample_rdy1 = 1'b1;
      tick();
      total++; if (avg_vld1 !== 1'b1) begin bad++; $display("FAIL n1_vld got %b want 1", avg_vld1); end
      total++; if (avg_out1 !== vals[k]) begin bad++; $display("FAIL n1_avg got %h want %h", avg_out1, vals[k]); end
      total++; if (min_out1 !== vals[k] || max_out1 !== vals[k]) begin
        bad++; $display("FAIL n1_minmax got %h/%h want %h", min_out1, max_out1, vals[k]);
      end
      sample_rdy1 = 1'b0;
      tick();
      total++; if (vld1_cnt - v0 !== 1) begin bad++; $display("FAIL n1_pulses got %0d want 1", vld1_cnt - v0); end
    end
    total++; if (ovr1 !== 1'b0) begin bad++; $display("FAIL n1_ovr got %b want 0", ovr1); end
    total++; if (fill_cnt1 !== 7'd0) begin bad++; $display("FAIL n1_fill got %0d want 0", fill_cnt1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_held();
    test_clear_mid();
    test_reset_mid();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ad7705_sample_avg.md
AD7705_SAMPLE_AVG -- requirements
Module: ad7705_sample_avg

Interface
REQ-001 SHALL have parameter LOG2_N, default 3, meaning window length N = 2^LOG2_N samples; legal range 0..6.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sample_in  input  16  unipolar ADC code from the AD7705 serial interface, stable while sample_rdy high.
REQ-005 SHALL have port sample_rdy  input  1  level from upstream; each 0->1 transition marks one new sample.
REQ-006 SHALL have port clear  input  1  synchronous flush of window, min/max and sticky flag.
REQ-007 SHALL have port avg_out  output  16  rounded mean of the last completed window.
REQ-008 SHALL have port avg_vld  output  1  one-cycle pulse when avg_out updates.
REQ-009 SHALL have port min_out  output  16  minimum sample of the last completed window.
REQ-010 SHALL have port max_out  output  16  maximum sample of the last completed window.
REQ-011 SHALL have port fill_cnt  output  7  samples accepted in the current window (0..N-1).
REQ-012 SHALL have port ovr  output  1  sticky rail flag.

Function
REQ-013 SHALL register sample_rdy into rdy_q; accept = sample_rdy & ~rdy_q, combinational in the rise cycle; a held-high sample_rdy counts once.
REQ-014 SHALL keep a two-state FSM: EMPTY (fill_cnt==0, no partial sum) and ACCUM (1..N-1 samples held); EMPTY->ACCUM on accept when N>1; ACCUM->EMPTY on the Nth accept or clear.
REQ-015 SHALL keep accumulator width 16+LOG2_N bits; never overflows since N*FFFF fits.
REQ-016 SHALL, on a non-final accept, add sample_in to the accumulator, increment fill_cnt, and update running min/max at the edge ending the accept cycle.
REQ-017 SHALL, on the Nth accept, compute (sum + sample_in + 2^(LOG2_N-1)) >> LOG2_N (no rounding term when LOG2_N=0), saturate to FFFF, load avg_out, load min_out/max_out from the running values including that sample, pulse avg_vld, and reset accumulator, fill_cnt and running min/max, all at the same edge.
REQ-018 SHALL have latency: avg_vld high in the cycle immediately after the Nth sample_rdy rise cycle, for exactly one cycle.
REQ-019 SHALL restart running min at FFFF and running max at 0000 at each window start, so the first sample of a window always sets both.
REQ-020 SHALL, with LOG2_N=0, pulse avg_vld for every accept with avg_out=min_out=max_out=sample_in; FSM stays EMPTY.
REQ-021 SHALL set ovr at the accept edge when sample_in==0000 or FFFF; ovr remains set until clear or reset.
REQ-022 SHALL give clear priority over accept in the same cycle: the sample is discarded, accumulator/fill_cnt/running min-max/ovr reset, FSM->EMPTY, avg_vld stays low; avg_out/min_out/max_out hold their last values.
REQ-023 SHALL still update rdy_q during clear, so a rise coinciding with clear is not re-accepted afterwards.
REQ-024 SHALL keep avg_out, min_out, max_out unchanged between avg_vld pulses.

Reset
REQ-025 SHALL, while rstn=0, drive avg_out=0000, min_out=0000, max_out=0000, avg_vld=0, fill_cnt=0, ovr=0, rdy_q=1, FSM=EMPTY, accumulator=0.
REQ-026 SHALL abandon a partial window on rstn assertion mid-window; a sample_rdy already high at rstn release is not accepted (rdy_q=1).

Verification
REQ-027 LOG2_N=3, eight rises with samples 1000..1007 -> one avg_vld, avg_out=1004 (round-half-up of 1003.5), min_out=1000, max_out=1007, fill_cnt back to 0.
REQ-028 LOG2_N=3, eight samples of FFFF -> avg_out=FFFF (saturated), ovr=1 sticky after the first, clear -> ovr=0, outputs held.
REQ-029 sample_rdy held high 20 cycles then low, repeated 8 times -> exactly 8 accepts, one avg_vld pulse.
REQ-030 Four samples accepted, then clear coinciding with a fifth rise -> fill_cnt=0, avg_vld never pulses; next 8 samples of 0100 -> avg_out=0100.
REQ-031 rstn pulsed low after 5 samples -> all outputs at reset values; 8 further samples of 2000 -> avg_out=2000, min_out=max_out=2000.
REQ-032 LOG2_N=0, samples 0001, 8000 -> avg_vld each time, avg_out tracks sample, ovr=0.
